// File: rtl/sensor_poll_scheduler.sv
// ---------------------------------------------------------------------------
// sensor_poll_scheduler
//   Periodically polls the GNSS receiver and then the altimeter over one
//   shared req/ack sensor bus, tracks consecutive non-answers per sensor,
//   fuses the two readings into one altitude sample and raises a sticky
//   emergency once both sensors are faulted.
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active-high
//   enable_i        1 = polling active
//   bus_req_o       request to the shared sensor bus
//   bus_sel_o       0 = GNSS, 1 = altimeter (valid while bus_req_o = 1)
//   bus_ack_i       sensor answer strobe, honoured only while bus_req_o = 1
//   bus_data_i      sensor altitude, captured together with the ack
//   alt_o           fused altitude, held between updates
//   alt_valid_o     one-cycle strobe: alt_o has just been updated
//   sensor_fault_o  sticky fault flags: [0] GNSS, [1] altimeter
//   emergency_o     sticky: both sensors faulted, polling halted
//   busy_o          1 while a polling round is in progress
// ---------------------------------------------------------------------------
module sensor_poll_scheduler #(
   parameter int unsigned POLL_PERIOD = 1000,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned MAX_MISS    = 3,
   parameter int unsigned DIFF_TH     = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   output logic        bus_req_o,
   output logic        bus_sel_o,
   input  logic        bus_ack_i,
   input  logic [15:0] bus_data_i,
   output logic [15:0] alt_o,
   output logic        alt_valid_o,
   output logic [1:0]  sensor_fault_o,
   output logic        emergency_o,
   output logic        busy_o
);

   localparam int unsigned CNT_W  = $clog2(POLL_PERIOD);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned MISS_W = $clog2(MAX_MISS + 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ_G = 3'd1,
      ST_REQ_A = 3'd2,
      ST_FUSE  = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                tick_pending_r;
   logic                take_tick_s;
   logic [TO_W-1:0]     wcnt_r, wcnt_s;
   logic                done_r, done_s;
   logic [15:0]         g_r, g_s, a_r, a_s;
   logic                got_g_r, got_g_s, got_a_r, got_a_s;
   logic [MISS_W-1:0]   miss_g_r, miss_g_s, miss_a_r, miss_a_s;
   logic                bus_req_r, bus_req_s;
   logic                bus_sel_r, bus_sel_s;
   logic [15:0]         alt_r, alt_s;
   logic                alt_valid_r, alt_valid_s;
   logic [1:0]          fault_r, fault_s;
   logic                emerg_r, emerg_s;
   logic                busy_r, busy_s;
   logic [16:0]         sum_s;
   logic [15:0]         avg_s;
   logic                sum_lsb_unused_s;
   logic [15:0]         diff_s;
   logic                timeout_s;

   assign bus_req_o      = bus_req_r;
   assign bus_sel_o      = bus_sel_r;
   assign alt_o          = alt_r;
   assign alt_valid_o    = alt_valid_r;
   assign sensor_fault_o = fault_r;
   assign emergency_o    = emerg_r;
   assign busy_o         = busy_r;

   // 17-bit sum keeps the average exact even for readings near 0xFFFF
   assign sum_s                     = {1'b0, g_r} + {1'b0, a_r};
   assign {avg_s, sum_lsb_unused_s} = sum_s;
   assign diff_s    = (g_r >= a_r) ? (g_r - a_r) : (a_r - g_r);
   assign timeout_s = (wcnt_r == TO_W'(TIMEOUT - 1));

   // Period counter and one-deep pending tick; disabling clears both
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r          <= '0;
         tick_pending_r <= 1'b0;
      end else if (!enable_i) begin
         cnt_r          <= '0;
         tick_pending_r <= 1'b0;
      end else if (cnt_r == CNT_W'(POLL_PERIOD - 1)) begin
         cnt_r          <= '0;
         tick_pending_r <= 1'b1;
      end else begin
         cnt_r <= cnt_r + CNT_W'(1);
         if (take_tick_s) begin
            tick_pending_r <= 1'b0;
         end else begin
            tick_pending_r <= tick_pending_r;
         end
      end
   end

   // State register plus all registered datapath values and outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         wcnt_r      <= '0;
         done_r      <= 1'b0;
         g_r         <= 16'd0;
         a_r         <= 16'd0;
         got_g_r     <= 1'b0;
         got_a_r     <= 1'b0;
         miss_g_r    <= '0;
         miss_a_r    <= '0;
         bus_req_r   <= 1'b0;
         bus_sel_r   <= 1'b0;
         alt_r       <= 16'd0;
         alt_valid_r <= 1'b0;
         fault_r     <= 2'b00;
         emerg_r     <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         wcnt_r      <= wcnt_s;
         done_r      <= done_s;
         g_r         <= g_s;
         a_r         <= a_s;
         got_g_r     <= got_g_s;
         got_a_r     <= got_a_s;
         miss_g_r    <= miss_g_s;
         miss_a_r    <= miss_a_s;
         bus_req_r   <= bus_req_s;
         bus_sel_r   <= bus_sel_s;
         alt_r       <= alt_s;
         alt_valid_r <= alt_valid_s;
         fault_r     <= fault_s;
         emerg_r     <= emerg_s;
         busy_r      <= busy_s;
      end
   end

   // Next-state and next-output logic of the polling round
   always_comb begin
      state_s     = state_r;
      wcnt_s      = wcnt_r;
      done_s      = done_r;
      g_s         = g_r;
      a_s         = a_r;
      got_g_s     = got_g_r;
      got_a_s     = got_a_r;
      miss_g_s    = miss_g_r;
      miss_a_s    = miss_a_r;
      bus_req_s   = 1'b0;
      bus_sel_s   = bus_sel_r;
      alt_s       = alt_r;
      alt_valid_s = 1'b0;
      fault_s     = fault_r;
      emerg_s     = emerg_r;
      take_tick_s = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (tick_pending_r && !emerg_r) begin
               take_tick_s = 1'b1;
               got_g_s     = 1'b0;
               got_a_s     = 1'b0;
               wcnt_s      = '0;
               done_s      = 1'b0;
               bus_req_s   = 1'b1;
               if (fault_r[0]) begin
                  state_s   = ST_REQ_A;
                  bus_sel_s = 1'b1;
               end else begin
                  state_s   = ST_REQ_G;
                  bus_sel_s = 1'b0;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_REQ_G: begin
            if (done_r) begin
               // one cycle with the request low before talking to the altimeter
               done_s = 1'b0;
               wcnt_s = '0;
               if (fault_r[1]) begin
                  state_s = ST_FUSE;
               end else begin
                  state_s   = ST_REQ_A;
                  bus_req_s = 1'b1;
                  bus_sel_s = 1'b1;
               end
            end else if (bus_req_r && bus_ack_i) begin
               g_s      = bus_data_i;
               got_g_s  = 1'b1;
               miss_g_s = '0;
               done_s   = 1'b1;
            end else if (timeout_s) begin
               got_g_s = 1'b0;
               done_s  = 1'b1;
               if (miss_g_r != MISS_W'(MAX_MISS)) begin
                  miss_g_s = miss_g_r + MISS_W'(1);
               end else begin
                  miss_g_s = miss_g_r;
               end
               if (int'(miss_g_r) + 1 >= int'(MAX_MISS)) begin
                  fault_s[0] = 1'b1;
               end else begin
                  fault_s[0] = fault_r[0];
               end
            end else begin
               bus_req_s = 1'b1;
               wcnt_s    = wcnt_r + TO_W'(1);
            end
         end

         ST_REQ_A: begin
            if (bus_req_r && bus_ack_i) begin
               a_s      = bus_data_i;
               got_a_s  = 1'b1;
               miss_a_s = '0;
               state_s  = ST_FUSE;
            end else if (timeout_s) begin
               got_a_s = 1'b0;
               state_s = ST_FUSE;
               if (miss_a_r != MISS_W'(MAX_MISS)) begin
                  miss_a_s = miss_a_r + MISS_W'(1);
               end else begin
                  miss_a_s = miss_a_r;
               end
               if (int'(miss_a_r) + 1 >= int'(MAX_MISS)) begin
                  fault_s[1] = 1'b1;
               end else begin
                  fault_s[1] = fault_r[1];
               end
            end else begin
               bus_req_s = 1'b1;
               wcnt_s    = wcnt_r + TO_W'(1);
            end
         end

         ST_FUSE: begin
            if (got_g_r && got_a_r) begin
               alt_valid_s = 1'b1;
               if (diff_s <= 16'(DIFF_TH)) begin
                  alt_s = avg_s;
               end else begin
                  alt_s = g_r;
               end
            end else if (got_g_r) begin
               alt_valid_s = 1'b1;
               alt_s       = g_r;
            end else if (got_a_r) begin
               alt_valid_s = 1'b1;
               alt_s       = a_r;
            end else begin
               alt_valid_s = 1'b0;
            end
            if (fault_r == 2'b11) begin
               state_s = ST_HALT;
               emerg_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_HALT: begin
            state_s = ST_HALT;
            emerg_s = 1'b1;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      busy_s = (state_s != ST_IDLE);
   end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sensor_poll_scheduler
//   Sensor-bus responder plus scoreboard: the responder answers requests with
//   configurable delay/data (or stays silent), keeps its own miss/fault model
//   and pushes the expected fused altitude when a round's requests end; each
//   alt_valid_o strobe pops and compares.
// ---------------------------------------------------------------------------
module tb_sensor_poll_scheduler;

   logic        clk;
   logic        rst;
   logic        enable_i;
   logic        bus_req_o;
   logic        bus_sel_o;
   logic        bus_ack_i;
   logic [15:0] bus_data_i;
   logic [15:0] alt_o;
   logic        alt_valid_o;
   logic [1:0]  sensor_fault_o;
   logic        emergency_o;
   logic        busy_o;

   sensor_poll_scheduler #(
      .POLL_PERIOD(40), .TIMEOUT(16), .MAX_MISS(3), .DIFF_TH(9)
   ) dut (
      .clk(clk), .rst(rst), .enable_i(enable_i),
      .bus_req_o(bus_req_o), .bus_sel_o(bus_sel_o),
      .bus_ack_i(bus_ack_i), .bus_data_i(bus_data_i),
      .alt_o(alt_o), .alt_valid_o(alt_valid_o),
      .sensor_fault_o(sensor_fault_o), .emergency_o(emergency_o),
      .busy_o(busy_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // sensor configuration, written by the main sequence only
   logic [15:0] g_val = 16'd0, a_val = 16'd0;
   int          g_delay = 2, a_delay = 2;
   logic        g_silent = 1'b0, a_silent = 1'b0, stray_en = 1'b0;

   // model state, owned by the responder process
   logic [15:0] exp_q[$];
   logic [1:0]  exp_fault = 2'b00;
   int          miss_m[2];
   int          strobe_cnt = 0;
   int          last_strobe_cyc = 0;
   int          g_rise_cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] fuse_exp(input logic rg, input logic ra,
                                            input logic [15:0] vg, input logic [15:0] va);
      logic [16:0] s;
      logic [15:0] d;
      if (rg && ra) begin
         d = (vg >= va) ? vg - va : va - vg;
         s = {1'b0, vg} + {1'b0, va};
         return (d <= 16'd9) ? s[16:1] : vg;
      end else if (rg) begin
         return vg;
      end else begin
         return va;
      end
   endfunction

   // responder + scoreboard, evaluated once per cycle on the falling edge
   initial begin : model
      logic        in_req, cur_sel, acked, rg, ra;
      logic [15:0] vg, va;
      int          age;
      in_req = 1'b0; cur_sel = 1'b0; acked = 1'b0; rg = 1'b0; ra = 1'b0;
      vg = 16'd0; va = 16'd0; age = 0;
      miss_m[0] = 0; miss_m[1] = 0;
      bus_ack_i = 1'b0; bus_data_i = 16'd0;
      forever begin
         @(negedge clk);
         bus_ack_i = 1'b0;
         if (rst) begin
            in_req = 1'b0; acked = 1'b0; rg = 1'b0; ra = 1'b0;
            miss_m[0] = 0; miss_m[1] = 0; exp_fault = 2'b00;
            exp_q.delete();
         end else begin
            if (alt_valid_o) begin
               strobe_cnt++;
               last_strobe_cyc = cyc;
               if (exp_q.size() == 0) begin
                  check_eq("unexpected_strobe", 32'd1, 32'd0);
               end else begin
                  check_eq("alt_o", 32'(alt_o), 32'(exp_q.pop_front()));
                  check_eq("fault_at_strobe", 32'(sensor_fault_o), 32'(exp_fault));
               end
            end
            if (bus_req_o) begin
               if (!in_req) begin
                  in_req = 1'b1; cur_sel = bus_sel_o; age = 0; acked = 1'b0;
                  if (!cur_sel) g_rise_cyc = cyc;
                  check_eq("req_to_faulted", 32'(exp_fault[cur_sel]), 32'd0);
               end else begin
                  age++;
               end
               if (!acked && age == (cur_sel ? a_delay : g_delay) &&
                   !(cur_sel ? a_silent : g_silent)) begin
                  acked = 1'b1;
                  bus_ack_i = 1'b1;
                  bus_data_i = cur_sel ? a_val : g_val;
                  if (cur_sel) begin ra = 1'b1; va = a_val; end
                  else begin rg = 1'b1; vg = g_val; end
               end
            end else begin
               if (in_req) begin
                  in_req = 1'b0;
                  if (acked) begin
                     miss_m[cur_sel] = 0;
                  end else begin
                     check_eq("timeout_len", 32'(age + 1), 32'd16);
                     miss_m[cur_sel]++;
                     if (miss_m[cur_sel] >= 3) exp_fault[cur_sel] = 1'b1;
                  end
                  if (cur_sel || exp_fault[1]) begin
                     if (rg || ra) exp_q.push_back(fuse_exp(rg, ra, vg, va));
                     rg = 1'b0; ra = 1'b0;
                  end
               end
               if (stray_en) begin
                  bus_ack_i = 1'b1;
                  bus_data_i = 16'hDEAD;
               end
            end
         end
      end
   end

   task automatic wait_strobes(input int n);
      int target;
      int budget;
      target = strobe_cnt + n;
      budget = n * 100;
      while (strobe_cnt < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("strobe_wait", 32'(strobe_cnt >= target), 32'd1);
   endtask

   task automatic wait_req(input logic sel);
      int budget;
      budget = 200;
      while (!(bus_req_o && bus_sel_o == sel) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("wait_req", 32'(budget > 0), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_req"},   32'(bus_req_o), 32'd0);
      check_eq({tag, "_alt"},   32'(alt_o), 32'd0);
      check_eq({tag, "_valid"}, 32'(alt_valid_o), 32'd0);
      check_eq({tag, "_fault"}, 32'(sensor_fault_o), 32'd0);
      check_eq({tag, "_emerg"}, 32'(emergency_o), 32'd0);
      check_eq({tag, "_busy"},  32'(busy_o), 32'd0);
   endtask

   initial begin : main
      int s2, reqs, budget;
      rst = 1'b1;
      enable_i = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // 1: close readings are averaged, one strobe per period
      g_val = 16'd100; a_val = 16'd104; g_delay = 2; a_delay = 2;
      enable_i = 1'b1;
      wait_strobes(2);
      s2 = last_strobe_cyc;
      wait_strobes(1);
      check_eq("period", 32'(last_strobe_cyc - s2), 32'd40);
      check_eq("latency", 32'(last_strobe_cyc - g_rise_cyc), 32'd8);

      // 2: divergent readings, overflow-free average, threshold edges, stray acks
      stray_en = 1'b1;
      g_val = 16'd100;   a_val = 16'd120;   wait_strobes(1);
      g_val = 16'hFFFF;  a_val = 16'hFFF8;  wait_strobes(1);
      g_val = 16'd200;   a_val = 16'd209;   wait_strobes(1);
      g_val = 16'd200;   a_val = 16'd210;   wait_strobes(1);
      stray_en = 1'b0;

      // 3: altimeter silent -> faulted after the third timeout, then skipped
      g_val = 16'd777; a_silent = 1'b1;
      wait_strobes(3);
      check_eq("alt_fault", 32'(sensor_fault_o), 32'd2);
      wait_strobes(2);

      // 4: GNSS misses twice then recovers; three more misses fault it
      do_reset();
      a_silent = 1'b0; g_silent = 1'b1; a_val = 16'd500; g_val = 16'd510;
      g_delay = 1; a_delay = 1;
      wait_strobes(2);
      g_silent = 1'b0;
      wait_strobes(1);
      check_eq("no_fault_after_recover", 32'(sensor_fault_o), 32'd0);
      g_silent = 1'b1;
      wait_strobes(3);
      check_eq("gnss_fault", 32'(sensor_fault_o), 32'd1);
      wait_strobes(1);

      // 6: enable falls during the altimeter request; round still completes
      do_reset();
      g_silent = 1'b0; g_val = 16'd300; a_val = 16'd302; a_delay = 5;
      wait_req(1'b1);
      enable_i = 1'b0;
      wait_strobes(1);
      @(negedge clk);
      check_eq("busy_after_disable", 32'(busy_o), 32'd0);
      reqs = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus_req_o) reqs++;
      end
      check_eq("no_req_disabled", 32'(reqs), 32'd0);

      // 6b: reset in the middle of the GNSS request
      enable_i = 1'b1;
      wait_req(1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // 5: both sensors silent -> emergency and permanent halt
      g_silent = 1'b1; a_silent = 1'b1;
      budget = 600;
      while (!emergency_o && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check_eq("emerg_wait", 32'(budget > 0), 32'd1);
      check_eq("emerg_fault", 32'(sensor_fault_o), 32'd3);
      check_eq("emerg_model", 32'(exp_fault), 32'd3);
      check_eq("emerg_busy", 32'(busy_o), 32'd1);
      reqs = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus_req_o) reqs++;
      end
      check_eq("no_req_halt", 32'(reqs), 32'd0);
      check_eq("emerg_sticky", 32'(emergency_o), 32'd1);
      do_reset();
      @(negedge clk);
      check_eq("emerg_cleared", 32'(emergency_o), 32'd0);
      check_eq("fault_cleared", 32'(sensor_fault_o), 32'd0);

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
